// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial arithmetic cells.
// The state encoding is shared so that a later serial subtractor
// presents the same debug view as the adder.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/full_adder.sv
// One-bit full adder cell: the only arithmetic element of the serial adder.
module full_adder (
    input  logic x,
    input  logic y,
    input  logic z,
    output logic s,
    output logic c
);

    // Sum and majority carry of the three input bits.
    always_comb begin
        s = x ^ y ^ z;
        c = (x & y) | (x & z) | (y & z);
    end

endmodule

// File: rtl/serial_adder.sv
// Bit-serial ripple adder: sum = a + b + cin, one bit per clock, LSB first,
// through a single full adder cell.
//
// Handshake: start is a request, sampled only while idle (busy=0, done=0);
// the request is accepted at the rising edge where start=1 in IDLE, and a/b/cin
// are captured at that same edge. busy is high for the WIDTH cycles of the
// computation. done is a one-cycle pulse marking sum/cout valid. sum/cout hold
// their value until the next result completes. start is ignored while busy or
// done is high; requests are never queued.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output state_t           state_dbg
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res_sh;
    logic [WIDTH-1:0] res_next;
    logic             carry;
    logic [CW-1:0]    count;
    logic             last_bit;
    logic             fa_s;
    logic             fa_c;

    full_adder u_fa (
        .x (a_sh[0]),
        .y (b_sh[0]),
        .z (carry),
        .s (fa_s),
        .c (fa_c)
    );

    assign res_next  = {fa_s, res_sh[WIDTH-1:1]};
    assign last_bit  = (count == LAST);
    assign state_dbg = state;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode and handshake outputs.
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_next = S_RUN;
                end
            end
            S_RUN: begin
                busy = 1'b1;
                if (last_bit) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                done       = 1'b1;
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Operand/result shifting, carry and bit counter; result published on the last bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh   <= '0;
            b_sh   <= '0;
            res_sh <= '0;
            carry  <= 1'b0;
            count  <= '0;
            sum    <= '0;
            cout   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        carry <= cin;
                        count <= '0;
                    end
                end
                S_RUN: begin
                    a_sh   <= {1'b0, a_sh[WIDTH-1:1]};
                    b_sh   <= {1'b0, b_sh[WIDTH-1:1]};
                    res_sh <= res_next;
                    carry  <= fa_c;
                    if (last_bit) begin
                        sum  <= res_next;
                        cout <= fa_c;
                    end else begin
                        count <= count + CW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: an 8-bit instance for directed and random operations,
// and a 4-bit instance swept over every operand/carry combination.
module tb_serial_adder;
    import serial_adder_pkg::*;

    logic       clk = 1'b0;
    logic       rst;

    logic       start8, cin8, busy8, done8, cout8;
    logic [7:0] a8, b8, sum8;
    state_t     st8;

    logic       start4, cin4, busy4, done4, cout4;
    logic [3:0] a4, b4, sum4;
    state_t     st4;

    int         checks = 0;
    int         errors = 0;
    logic [8:0] exp_q[$];
    logic [8:0] last8 = '0;
    logic [8:0] last4 = '0;

    serial_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .state_dbg(st8)
    );

    serial_adder #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .cin(cin4),
        .busy(busy4), .done(done4), .sum(sum4), .cout(cout4), .state_dbg(st4)
    );

    // Clock.
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic busy_of(input bit sel4);
        return sel4 ? busy4 : busy8;
    endfunction

    function automatic logic done_of(input bit sel4);
        return sel4 ? done4 : done8;
    endfunction

    function automatic logic [8:0] res_of(input bit sel4);
        return sel4 ? {4'b0, cout4, sum4} : {cout8, sum8};
    endfunction

    // One operation: request in an idle cycle, then check busy for WIDTH cycles,
    // done in the following one, and the result against the arithmetic model.
    task automatic do_op(input bit sel4, input logic [7:0] aa, input logic [7:0] bb,
                         input logic ci);
        int         w;
        logic [8:0] prev;
        logic [8:0] exp;
        w    = sel4 ? 4 : 8;
        prev = sel4 ? last4 : last8;
        @(negedge clk);
        check("idle_busy", 32'(busy_of(sel4)), 32'd0);
        check("idle_done", 32'(done_of(sel4)), 32'd0);
        if (sel4) begin
            start4 = 1'b1; a4 = aa[3:0]; b4 = bb[3:0]; cin4 = ci;
            exp_q.push_back(9'(aa[3:0]) + 9'(bb[3:0]) + 9'(ci));
        end else begin
            start8 = 1'b1; a8 = aa; b8 = bb; cin8 = ci;
            exp_q.push_back(9'(aa) + 9'(bb) + 9'(ci));
        end
        for (int i = 1; i <= w; i++) begin
            @(negedge clk);
            if (i == 1) begin
                // Operands change after acceptance; the result must not follow.
                if (sel4) begin
                    start4 = 1'b0; a4 = 4'($urandom); b4 = 4'($urandom); cin4 = 1'($urandom);
                end else begin
                    start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
                end
            end
            check("run_busy", 32'(busy_of(sel4)), 32'd1);
            check("run_done", 32'(done_of(sel4)), 32'd0);
            check("run_hold", 32'(res_of(sel4)), 32'(prev));
        end
        @(negedge clk);
        exp = exp_q.pop_front();
        check("done_pulse", 32'(done_of(sel4)), 32'd1);
        check("done_busy", 32'(busy_of(sel4)), 32'd0);
        check("result", 32'(res_of(sel4)), 32'(exp));
        if (sel4) last4 = exp;
        else      last8 = exp;
    endtask

    initial begin
        logic [8:0] exp_h;
        rst = 1'b1;
        start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
        start4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_busy8", 32'(busy8), 32'd0);
        check("rst_done8", 32'(done8), 32'd0);
        check("rst_res8", 32'({cout8, sum8}), 32'd0);
        check("rst_state8", 32'(st8), 32'(S_IDLE));
        check("rst_busy4", 32'(busy4), 32'd0);
        check("rst_res4", 32'({cout4, sum4}), 32'd0);
        check("rst_state4", 32'(st4), 32'(S_IDLE));
        rst = 1'b0;

        // Directed operations, including overflow.
        do_op(1'b0, 8'h05, 8'h03, 1'b0);
        do_op(1'b0, 8'hFF, 8'h01, 1'b0);
        do_op(1'b0, 8'hFF, 8'hFF, 1'b1);
        do_op(1'b0, 8'h00, 8'h00, 1'b1);

        // start held high: one operation every WIDTH+2 cycles, inputs scrambled while busy.
        exp_h = 9'h010 + 9'h020;
        @(negedge clk);
        start8 = 1'b1; a8 = 8'h10; b8 = 8'h20; cin8 = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if ((i % 10) >= 1 && (i % 10) <= 8) begin
                a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
            end else begin
                a8 = 8'h10; b8 = 8'h20; cin8 = 1'b0;
            end
            check("held_busy", 32'(busy8), 32'((i % 10) >= 1 && (i % 10) <= 8));
            check("held_done", 32'(done8), 32'((i % 10) == 9));
            if ((i % 10) == 9) begin
                check("held_result", 32'({cout8, sum8}), 32'(exp_h));
                last8 = exp_h;
            end else begin
                check("held_hold", 32'({cout8, sum8}), 32'(last8));
            end
        end
        start8 = 1'b0;

        // Reset mid-computation: outputs clear at once, no done pulse follows.
        @(negedge clk);
        start8 = 1'b1; a8 = 8'hAA; b8 = 8'h77; cin8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_busy", 32'(busy8), 32'd0);
        check("mid_rst_done", 32'(done8), 32'd0);
        check("mid_rst_res", 32'({cout8, sum8}), 32'd0);
        last8 = '0;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check("post_rst_done", 32'(done8), 32'd0);
            check("post_rst_busy", 32'(busy8), 32'd0);
        end
        do_op(1'b0, 8'h7F, 8'h01, 1'b0);

        // Random 8-bit operations, back to back at minimum spacing.
        for (int n = 0; n < 30; n++) begin
            do_op(1'b0, 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
        end

        // Exhaustive 4-bit sweep.
        for (int x = 0; x < 16; x++) begin
            for (int y = 0; y < 16; y++) begin
                for (int c = 0; c < 2; c++) begin
                    do_op(1'b1, 8'(x), 8'(y), 1'(c));
                end
            end
        end
        @(negedge clk);
        check("final_done4", 32'(done4), 32'd0);
        check("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
